// File: rtl/snake_pkg.sv
// snake_pkg: matrix geometry, command opcodes and frame-buffer state encoding
package snake_pkg;
    localparam int MATRIX_ROWS = 8;
    localparam int MATRIX_COLS = 16;
    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_CLEAR = 2'b01,
        OP_FILL  = 2'b10,
        OP_SWAP  = 2'b11
    } op_t;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROWOP,
        ST_SWAP_WAIT
    } state_t;
endpackage

// File: rtl/frame_buffer.sv
// frame_buffer: double-buffered LED-matrix pixel store with frame-synchronised swap
module frame_buffer
    import snake_pkg::*;
#(
    parameter int ROWS      = MATRIX_ROWS,
    parameter int COLS      = MATRIX_COLS,
    parameter int SWAP_SYNC = 1,
    localparam int RW       = $clog2(ROWS),
    localparam int CW       = $clog2(COLS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [CW-1:0]        cmd_x,
    input  logic [RW-1:0]        cmd_y,
    input  logic                 cmd_val,
    input  logic                 frame_tick,
    input  logic [CW-1:0]        rd_x,
    input  logic [RW-1:0]        rd_y,
    output logic                 rd_pixel,
    output logic                 swap_done,
    output logic [ROWS*COLS-1:0] pixel_rows
);
    state_t                   state, state_nx;
    logic [RW-1:0]            row;
    logic                     fill_val, accept, row_we, wr_we, swap_now, swap_q;
    logic [ROWS-1:0][COLS-1:0] back, front;

    always_ff @(posedge clk) begin
        state <= !rst_n ? ST_IDLE : state_nx;
    end

    always_comb begin
        state_nx = accept && (cmd_op == OP_CLEAR || cmd_op == OP_FILL) ? ST_ROWOP :
                   accept && cmd_op == OP_SWAP && SWAP_SYNC != 0       ? ST_SWAP_WAIT :
                   (state == ST_ROWOP && row == RW'(ROWS - 1)) ||
                   (state == ST_SWAP_WAIT && frame_tick)                ? ST_IDLE : state;
    end

    always_comb begin
        cmd_ready = rst_n && state == ST_IDLE;
        accept    = cmd_valid && cmd_ready;
        row_we    = state == ST_ROWOP;
        wr_we     = accept && cmd_op == OP_WRITE && 32'(cmd_x) < COLS && 32'(cmd_y) < ROWS;
        swap_now  = SWAP_SYNC != 0 ? state == ST_SWAP_WAIT && frame_tick : accept && cmd_op == OP_SWAP;
        swap_done = SWAP_SYNC != 0 ? rst_n && swap_now : swap_q;
    end

    // Row fills take priority; a WRITE cannot be accepted while ROWOP is busy anyway
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            back     <= '0;
            front    <= '0;
            row      <= '0;
            fill_val <= 1'b0;
            swap_q   <= 1'b0;
        end else begin
            if (row_we)
                back[row] <= {COLS{fill_val}};
            else if (wr_we)
                back[cmd_y][cmd_x] <= cmd_val;
            if (swap_now)
                front <= back;
            row    <= row_we ? row + 1'b1 : '0;
            swap_q <= swap_now;
            if (accept)
                fill_val <= cmd_op == OP_FILL;
        end
    end

    assign rd_pixel   = back[rd_y][rd_x];
    assign pixel_rows = front;
endmodule

// File: doc/frame_buffer.md
Name: frame_buffer

Overview:
- Double-buffered 8x16 pixel store that sits directly upstream of the LED-matrix row scanner.
- Game logic draws into a back buffer through a single command handshake: write pixel, clear, fill, swap.
- The front buffer drives the scanner's 128-bit pixel bus continuously.
- Swaps are synchronised to a frame tick, so the scanner never shows a half-drawn frame.

Parameters:
- ROWS, 8, number of matrix rows (row index width RW = clog2(ROWS) = 3)
- COLS, 16, pixels per row (column index width CW = clog2(COLS) = 4)
- SWAP_SYNC, 1, 1 = swap waits for frame_tick; 0 = swap completes on the cycle after acceptance

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block idle; command accepted when cmd_valid && cmd_ready
- cmd_op  in  2  00 WRITE, 01 CLEAR, 10 FILL, 11 SWAP
- cmd_x  in  CW  column for WRITE
- cmd_y  in  RW  row for WRITE
- cmd_val  in  1  pixel value for WRITE
- frame_tick  in  1  one-cycle pulse marking a scan-frame boundary
- rd_x  in  CW  back-buffer read column
- rd_y  in  RW  back-buffer read row
- rd_pixel  out  1  combinational back[rd_y][rd_x] (for collision checks)
- swap_done  out  1  one-cycle pulse when the front buffer updates
- pixel_rows  out  ROWS*COLS  front buffer; row r at bits [COLS*r+COLS-1 : COLS*r], pixel (c,r) at bit COLS*r+c

Behaviour:
- Reset (rst_n=0 at an edge):
  - front and back buffers cleared to 0; state IDLE; swap_done 0.
  - cmd_ready is 0 while rst_n is low, including the reset cycle itself.
  - Any in-progress CLEAR, FILL or SWAP is aborted.
- cmd_ready = rst_n && state==IDLE. Commands are ignored unless accepted.
- States: IDLE, ROWOP, SWAP_WAIT.
- WRITE (accepted in IDLE):
  - back[cmd_y][cmd_x] <= cmd_val at that edge; state stays IDLE.
  - Back-to-back writes sustain 1 per cycle.
  - rd_pixel reflects the write from the next cycle.
- CLEAR / FILL:
  - Go to ROWOP with row counter 0 and latched value (CLEAR=0, FILL=1).
  - Each ROWOP cycle writes all COLS bits of back[row] with the latched value and increments row.
  - After writing row ROWS-1, return to IDLE. Busy for exactly ROWS cycles; cmd_ready returns high on cycle ROWS+1 after acceptance.
- SWAP, SWAP_SYNC=1:
  - Go to SWAP_WAIT.
  - frame_tick is ignored on the acceptance cycle; it is sampled only while in SWAP_WAIT.
  - On the first SWAP_WAIT cycle with frame_tick=1: front <= back, swap_done pulses that cycle, return to IDLE.
- SWAP, SWAP_SYNC=0: front <= back on the acceptance edge; swap_done high the following cycle; no state change.
- Swap copies back to front. The back buffer is preserved, allowing incremental redraw.
- pixel_rows is registered and changes only on a swap or on reset.
- Illegal or out-of-range coordinates cannot occur with power-of-2 ROWS/COLS. With non-power-of-2 sizes, WRITE to x>=COLS or y>=ROWS is accepted and discarded.
- frame_tick in IDLE or ROWOP has no effect.

Decomposition:
- Shared package snake_pkg:
  - constants MATRIX_ROWS=8, MATRIX_COLS=16
  - cmd_op encodings OP_WRITE, OP_CLEAR, OP_FILL, OP_SWAP
  - state encoding
- No sub-module required. The back-buffer row write (row-select mux plus bit-set) is kept inline.

Test Plan:
- Reset, then WRITE (x=3,y=2,val=1), SWAP, frame_tick two cycles later -> pixel_rows == 128'h1 << 35; swap_done pulses exactly once, in the tick cycle; pixel_rows 0 before the tick.
- FILL accepted at cycle t -> cmd_ready low for t+1..t+8, high at t+9; rd_pixel=1 at every (x,y); pixel_rows still 0 until a swap.
- After FILL+SWAP, issue CLEAR, then WRITE (15,7,1), then SWAP with tick -> pixel_rows == 128'h8000 << 112 (only bit 127 set).
- frame_tick asserted on the SWAP acceptance cycle only, next tick 10 cycles later -> front unchanged for those 10 cycles; updates at the second tick.
- rst_n low mid-ROWOP (row=4) and during SWAP_WAIT -> next cycle pixel_rows==0, rd_pixel==0 everywhere, cmd_ready==0 while rst_n low and 1 the cycle after release.
- SWAP_SYNC=0 build: 16 back-to-back WRITEs on row 0 with val=1, then SWAP -> pixel_rows[15:0]==16'hFFFF on the cycle after acceptance; swap_done high that same cycle.
